ets_sweep_ctrl: RTL and testbench

ETS_SWEEP_CTRL -- requirements
Module: ets_sweep_ctrl

---
 rtl/ets_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_ets_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ets_sweep_ctrl.sv
// Equivalent-time sampling sweep controller: steps the MMCM phase between captures,
// forwards one sample per step and optionally rewinds the phase back to origin.
module ets_sweep_ctrl #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic              cfg_rewind,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] ps_pos,
    output logic              core_en,
    input  logic              core_valid,
    input  logic [31:0]       core_data,
    output logic              core_ready,
    input  logic              core_ps_en,
    input  logic              core_ps_incdec,
    output logic              core_ps_done,
    output logic              ps_en,
    output logic              ps_incdec,
    input  logic              ps_done,
    output logic [31:0]       m_data,
    output logic [STEP_W-1:0] m_index,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    typedef enum logic [2:0] {
        IDLE, ARM, CAPTURE, PHASE, REWIND, REWAIT, FIN
    } state_t;

    state_t            r_state, w_next;
    logic [STEP_W-1:0] r_steps;
    logic              r_rewind;
    logic [STEP_W-1:0] r_idx;
    logic [STEP_W-1:0] r_pos;
    logic              r_abort_pend;
    logic              r_aborted;

    logic              w_active;
    logic              w_abort_pend;
    logic [STEP_W-1:0] w_idx_inc;
    logic [STEP_W-1:0] w_pos_inc;
    logic              w_last_step;

    assign w_active     = (r_state == ARM) || (r_state == CAPTURE) || (r_state == PHASE);
    // A same-cycle abort already counts, so the beat in flight can carry m_last.
    assign w_abort_pend = r_abort_pend || (w_active && abort);
    assign w_idx_inc    = r_idx + STEP_W'(1);
    assign w_pos_inc    = r_pos + STEP_W'(1);
    assign w_last_step  = (w_idx_inc == r_steps);

    assign aborted = r_aborted;
    assign ps_pos  = r_pos;
    assign m_index = r_idx;

    always_comb begin
        w_next       = r_state;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        core_en      = 1'b0;
        core_ready   = 1'b0;
        core_ps_done = 1'b0;
        ps_en        = 1'b0;
        ps_incdec    = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        m_data       = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (cfg_steps != '0) ? ARM : FIN;
            end
            ARM: begin
                core_en = 1'b1;
                w_next  = CAPTURE;
            end
            CAPTURE: begin
                m_valid    = core_valid;
                m_data     = core_data;
                core_ready = m_ready;
                m_last     = w_last_step || w_abort_pend;
                if (core_valid && m_ready) w_next = PHASE;
            end
            PHASE: begin
                ps_en        = core_ps_en;
                ps_incdec    = core_ps_incdec;
                core_ps_done = ps_done;
                if (ps_done) begin
                    if (w_last_step || w_abort_pend)
                        w_next = (r_rewind && (w_pos_inc != '0)) ? REWIND : FIN;
                    else
                        w_next = ARM;
                end
            end
            REWIND: begin
                if (r_pos == '0) begin
                    w_next = FIN;
                end else begin
                    ps_en  = 1'b1;
                    w_next = REWAIT;
                end
            end
            REWAIT: begin
                if (ps_done) w_next = REWIND;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_steps      <= '0;
            r_rewind     <= 1'b0;
            r_idx        <= '0;
            r_pos        <= '0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_active && abort) r_abort_pend <= 1'b1;
            if ((w_next == FIN) && (r_state != IDLE) && (r_state != FIN))
                r_aborted <= w_abort_pend;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_steps      <= cfg_steps;
                        r_rewind     <= cfg_rewind;
                        r_idx        <= '0;
                        r_abort_pend <= 1'b0;
                        r_aborted    <= 1'b0;
                    end
                end
                PHASE: begin
                    if (ps_done) begin
                        r_pos <= w_pos_inc;
                        // Index stays on the final step so m_index never reaches steps.
                        if (!(w_last_step || w_abort_pend)) r_idx <= w_idx_inc;
                    end
                end
                REWAIT: begin
                    if (ps_done) r_pos <= r_pos - STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Bench for ets_sweep_ctrl: sampler-core and MMCM models, per-beat scoreboard,
// directed sweep table, stall/reset sequences and randomized sweeps vs a sweep-level model.
module tb_ets_sweep_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, cfg_rewind;
    logic [W-1:0]  cfg_steps;
    logic          busy, done, aborted;
    logic [W-1:0]  ps_pos;
    logic          core_en, core_valid, core_ready, core_ps_en, core_ps_incdec, core_ps_done;
    logic [31:0]   core_data;
    logic          ps_en, ps_incdec, ps_done;
    logic [31:0]   m_data;
    logic [W-1:0]  m_index;
    logic          m_last, m_valid, m_ready;

    always #5 clk = ~clk;

    ets_sweep_ctrl #(.STEP_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_steps(cfg_steps), .cfg_rewind(cfg_rewind),
        .busy(busy), .done(done), .aborted(aborted), .ps_pos(ps_pos),
        .core_en(core_en), .core_valid(core_valid), .core_data(core_data),
        .core_ready(core_ready), .core_ps_en(core_ps_en), .core_ps_incdec(core_ps_incdec),
        .core_ps_done(core_ps_done), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    logic [31:0] dq[$];
    int  beat_tot = 0, done_tot = 0, rw_tot = 0, coreen_tot = 0;
    int  exp_idx = 0;
    int  cur_steps = 0;
    bit  abort_sent = 0;
    int  rdy_mode = 0;

    // Monitor: every delivered beat against the core's data queue and expected index/last.
    always @(negedge clk) begin
        if (!reset) begin
            if (start && !busy) exp_idx = 0;
            if (m_valid && m_ready) begin
                beat_tot++;
                chk("m_index", m_index, exp_idx);
                chk("m_last", m_last, (exp_idx == cur_steps - 1) || abort || abort_sent);
                if (dq.size() == 0) chk("beat_has_data", 0, 1);
                else chk("m_data", m_data, dq.pop_front());
                exp_idx++;
            end
            if (done) done_tot++;
            if (core_en) coreen_tot++;
            if (ps_en && !ps_incdec) rw_tot++;
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Sampler core: one sample per core_en, then one increment request.
    initial begin
        core_valid = 0; core_data = 0; core_ps_en = 0; core_ps_incdec = 0;
        forever begin
            @(negedge clk);
            if (core_en && !reset) begin
                @(posedge clk);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1 core_valid = 1'b1; core_data = $urandom; dq.push_back(core_data);
                forever begin
                    @(negedge clk);
                    if (reset || core_ready) break;
                end
                @(posedge clk); #1 core_valid = 1'b0;
                if (!reset) begin
                    core_ps_en = 1'b1; core_ps_incdec = 1'b1;
                    @(posedge clk); #1 core_ps_en = 1'b0; core_ps_incdec = 1'b0;
                end
            end
        end
    end

    // MMCM: ps_done four cycles after each ps_en request.
    initial begin
        ps_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ps_en && !reset) begin
                repeat (4) @(posedge clk);
                #1 ps_done = 1'b1;
                @(posedge clk); #1 ps_done = 1'b0;
            end
        end
    end

    function automatic void model(input int steps, input bit rw, input int ab, input int pos_in,
                                  output int beats, output int rws, output int pos_out, output bit abd);
        abd     = (ab >= 0) && (ab < steps);
        beats   = abd ? ab + 1 : steps;
        pos_out = (pos_in + beats) % (1 << W);
        rws     = (rw && beats > 0 && pos_out != 0) ? pos_out : 0;
        if (rws != 0) pos_out = 0;
    endfunction

    task automatic run_sweep(input string tag, input int steps, input bit rw, input int abort_at,
                             input int rdy, input int e_beats, input int e_rw, input int e_pos,
                             input bit e_ab);
        int b0, d0, r0, c0, cyc;
        b0 = beat_tot; d0 = done_tot; r0 = rw_tot; c0 = coreen_tot;
        rdy_mode = rdy; cur_steps = steps; abort_sent = 0;
        @(posedge clk); #1 cfg_steps = W'(steps); cfg_rewind = rw; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (done_tot == d0 && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (abort_at >= 0 && !abort_sent && core_en && (beat_tot - b0) == abort_at) begin
                abort_sent = 1;
                @(posedge clk); #1 abort = 1'b1;
                @(posedge clk); #1 abort = 1'b0;
            end
        end
        chk({tag, "_done_seen"}, done_tot != d0, 1);
        repeat (2) @(negedge clk);
        chk({tag, "_beats"}, beat_tot - b0, e_beats);
        chk({tag, "_core_en"}, coreen_tot - c0, e_beats);
        chk({tag, "_rewinds"}, rw_tot - r0, e_rw);
        chk({tag, "_ps_pos"}, ps_pos, e_pos);
        chk({tag, "_aborted"}, aborted, e_ab);
        chk({tag, "_done_cnt"}, done_tot - d0, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    typedef struct {
        int steps; bit rw; int abort_at; int rdy;
        int e_beats; int e_rw; int e_pos; bit e_ab;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int ref_pos, d0, cyc, eb, er, ep;
        bit ea;
        logic [31:0] held;
        reset = 1'b1; start = 0; abort = 0; cfg_rewind = 0; cfg_steps = '0;

        tbl[0] = '{4, 1, -1, 1, 4, 4, 0, 0};   // rewind after 4 steps
        tbl[1] = '{8, 1,  2, 0, 3, 3, 0, 1};   // abort in step 2 capture
        tbl[2] = '{3, 0, -1, 1, 3, 0, 3, 0};   // plain 3-step sweep
        tbl[3] = '{0, 1, -1, 0, 0, 0, 3, 0};   // empty sweep
        tbl[4] = '{2, 0,  0, 0, 1, 0, 4, 1};
        tbl[5] = '{1, 1, -1, 0, 1, 5, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, aborted, core_en, core_ready, core_ps_done, ps_en,
                              ps_incdec, m_valid, m_last, m_data, m_index, ps_pos}, '0);
        @(posedge clk); #1 reset = 1'b0;

        foreach (tbl[i])
            run_sweep($sformatf("vec%0d", i), tbl[i].steps, tbl[i].rw, tbl[i].abort_at, tbl[i].rdy,
                      tbl[i].e_beats, tbl[i].e_rw, tbl[i].e_pos, tbl[i].e_ab);
        ref_pos = 0;

        // Backpressure: sample must hold while m_ready is low; a second start is ignored.
        rdy_mode = 2; cur_steps = 2; abort_sent = 0; d0 = done_tot;
        @(posedge clk); #1 cfg_steps = W'(2); cfg_rewind = 0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!m_valid && cyc < 50);
        chk("stall_valid_seen", m_valid, 1);
        held = m_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin cfg_steps = W'(7); start = 1'b1; end
            if (i == 4) start = 1'b0;
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, held);
            chk("stall_core_ready", core_ready, 0);
            chk("stall_m_index", m_index, 0);
        end
        rdy_mode = 1;
        cyc = 0;
        while (done_tot == d0 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("stall_done_seen", done_tot != d0, 1);
        repeat (6) @(negedge clk);
        chk("stall_ps_pos", ps_pos, 2);
        chk("stall_single_done", done_tot - d0, 1);
        chk("stall_idle_after", busy, 0);
        ref_pos = 2;

        // Reset during the rewind wait abandons the sweep without a done pulse.
        rdy_mode = 1; cur_steps = 2; abort_sent = 0;
        @(posedge clk); #1 cfg_steps = W'(2); cfg_rewind = 1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(ps_en && !ps_incdec) && cyc < 500);
        chk("rewind_seen", ps_en && !ps_incdec, 1);
        d0 = done_tot;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {busy, done, aborted, core_en, core_ready, core_ps_done, ps_en,
                                 ps_incdec, m_valid, m_last, m_data, m_index, ps_pos}, '0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midreset_no_done", done_tot - d0, 0);
        ref_pos = 0;
        run_sweep("post_reset", 2, 0, -1, 0, 2, 0, 2, 0);
        ref_pos = 2;

        for (int i = 0; i < 8; i++) begin
            int steps, ab;
            bit rw;
            steps = $urandom_range(0, 5);
            rw    = 1'($urandom_range(0, 1));
            ab    = (steps > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, steps - 1)) : -1;
            model(steps, rw, ab, ref_pos, eb, er, ep, ea);
            run_sweep($sformatf("rand%0d", i), steps, rw, ab, 0, eb, er, ep, ea);
            ref_pos = ep;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
